// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: operand selects, FSM states, SP reset value.
package mem_stage_pkg;

    localparam logic [7:0] SP_INIT_DEFAULT = 8'hFF;

    localparam logic [1:0] ADDR_SEL_ALU   = 2'd0;
    localparam logic [1:0] ADDR_SEL_SRC1  = 2'd1;
    localparam logic [1:0] ADDR_SEL_IMM   = 2'd2;
    localparam logic [1:0] ADDR_SEL_STACK = 2'd3;

    localparam logic [1:0] WDATA_SEL_SRC1 = 2'd0;
    localparam logic [1:0] WDATA_SEL_SRC2 = 2'd1;
    localparam logic [1:0] WDATA_SEL_PC1  = 2'd2;
    localparam logic [1:0] WDATA_SEL_ALU  = 2'd3;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_IMM  = 2'd2;
    localparam logic [1:0] WB_SEL_SRC2 = 2'd3;

    typedef enum logic {IDLE, WAIT} mem_state_e;

endpackage

// File: rtl/mem_sp_reg.sv
// Stack pointer register; a completed push decrements, a completed pop increments (both wrap).
module mem_sp_reg #(
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic              pop_en,
    output logic [DATA_W-1:0] sp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sp <= SP_INIT;
        else if (push_en) sp <= sp - DATA_W'(1);
        else if (pop_en)  sp <= sp + DATA_W'(1);
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: data-memory handshake, stack pointer ownership, RET redirect and MEM/WB register.
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_valid,
    input  logic              m_rd,
    input  logic              m_wr,
    input  logic              m_sp_op,
    input  logic              m_ret,
    input  logic [1:0]        m_addr_sel,
    input  logic [1:0]        m_wdata_sel,
    input  logic [1:0]        m_wb_sel,
    input  logic              m_rf_we,
    input  logic [1:0]        m_dest,
    input  logic [DATA_W-1:0] m_pc,
    input  logic [DATA_W-1:0] m_imm,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_src1,
    input  logic [DATA_W-1:0] m_src2,
    input  logic              flush_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_o,
    output logic [DATA_W-1:0] sp_o,
    output logic              redir_valid,
    output logic [DATA_W-1:0] redir_pc,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [1:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data
);

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] sp, addr, wdata, wb_mux;
    logic              is_wr, is_rd, push, pop, mem_op, issue, done, kill, ret_done;

    // A malformed rd+wr bundle is treated as a write.
    assign is_wr  = m_wr;
    assign is_rd  = m_rd & ~m_wr;
    assign push   = m_sp_op & is_wr;
    assign pop    = m_sp_op & is_rd;
    assign mem_op = m_valid & (m_rd | m_wr);

    // Once in WAIT the access is committed; flush only kills accesses not yet started.
    assign issue    = rst_n & ((state_q == WAIT) | (mem_op & ~flush_i));
    assign done     = issue & dmem_ack;
    assign kill     = flush_i & (state_q == IDLE);
    assign ret_done = done & m_ret & is_rd;

    always_comb begin
        case (m_addr_sel)
            ADDR_SEL_ALU:  addr = m_alu;
            ADDR_SEL_SRC1: addr = m_src1;
            ADDR_SEL_IMM:  addr = m_imm;
            default:       addr = pop ? sp + DATA_W'(1) : sp;
        endcase
        case (m_wdata_sel)
            WDATA_SEL_SRC1: wdata = m_src1;
            WDATA_SEL_SRC2: wdata = m_src2;
            WDATA_SEL_PC1:  wdata = m_pc + DATA_W'(1);
            default:        wdata = m_alu;
        endcase
        case (m_wb_sel)
            WB_SEL_ALU: wb_mux = m_alu;
            WB_SEL_MEM: wb_mux = dmem_rdata;
            WB_SEL_IMM: wb_mux = m_imm;
            default:    wb_mux = m_src2;
        endcase
    end

    assign dmem_req   = issue;
    assign dmem_we    = issue & is_wr;
    assign dmem_addr  = issue ? addr : '0;
    assign dmem_wdata = (issue & is_wr) ? wdata : '0;
    assign stall_o    = issue & ~dmem_ack;
    assign sp_o       = sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue & ~dmem_ack) state_d = WAIT;
            WAIT:    if (dmem_ack)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_sp_reg #(.DATA_W(DATA_W), .SP_INIT(SP_INIT)) u_sp (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_en (done & push),
        .pop_en  (done & pop),
        .sp      (sp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_dest     <= '0;
            wb_data     <= '0;
        end else begin
            redir_valid <= ret_done;
            redir_pc    <= ret_done ? dmem_rdata : '0;
            if (stall_o) begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end else begin
                wb_valid <= m_valid & ~kill & ~m_ret;
                wb_we    <= m_valid & ~kill & ~m_ret & m_rf_we;
                wb_dest  <= m_dest;
                wb_data  <= wb_mux;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a transaction-level model checked every negedge.
module tb_mem_stage_unit;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       m_valid, m_rd, m_wr, m_sp_op, m_ret, m_rf_we, flush_i;
    logic [1:0] m_addr_sel, m_wdata_sel, m_wb_sel, m_dest;
    logic [7:0] m_pc, m_imm, m_alu, m_src1, m_src2;
    logic       dmem_req, dmem_we, dmem_ack, stall_o, redir_valid, wb_valid, wb_we;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata, sp_o, redir_pc, wb_data;
    logic [1:0] wb_dest;

    always #5 clk = ~clk;

    mem_stage_unit dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_rd(m_rd), .m_wr(m_wr),
        .m_sp_op(m_sp_op), .m_ret(m_ret), .m_addr_sel(m_addr_sel), .m_wdata_sel(m_wdata_sel),
        .m_wb_sel(m_wb_sel), .m_rf_we(m_rf_we), .m_dest(m_dest), .m_pc(m_pc), .m_imm(m_imm),
        .m_alu(m_alu), .m_src1(m_src1), .m_src2(m_src2), .flush_i(flush_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_o(stall_o), .sp_o(sp_o),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_dest(wb_dest), .wb_data(wb_data)
    );

    typedef struct packed {
        logic v, rd, wr, sp, ret;
        logic [1:0] as, ws, wbs;
        logic rfwe;
        logic [1:0] dest;
        logic [7:0] pc, imm, alu, s1, s2;
    } bun_t;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Memory slave: acks after wait_n cycles of request, read data combinational.
    logic [7:0] resp_mem [256] = '{default: 8'h00};
    int         wait_n = 0, cnt = 0, n_writes = 0;
    logic [7:0] last_addr = 8'h00;

    assign dmem_ack   = dmem_req && (cnt == wait_n);
    assign dmem_rdata = resp_mem[dmem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else begin
            cnt <= (dmem_req && !dmem_ack) ? cnt + 1 : 0;
            if (dmem_req && dmem_ack) begin
                last_addr <= dmem_addr;
                if (dmem_we) begin
                    resp_mem[dmem_addr] <= dmem_wdata;
                    n_writes <= n_writes + 1;
                end
            end
        end
    end

    // Transaction model: pending access flag, SP, own memory image, expected registered outputs.
    logic       busy, e_wv, e_we, e_dk, e_rv;
    logic [1:0] e_dest;
    logic [7:0] mdl_sp, e_data, e_rpc;
    logic [7:0] mdl_mem [256] = '{default: 8'h00};
    int         stall_cycles = 0;

    always @(negedge clk) begin : cmp
        logic live, req, fire, killed;
        logic [7:0] a, wd, rdm, wbd;
        if (!rst_n) begin
            busy <= 1'b0; mdl_sp <= 8'hFF; e_wv <= 1'b0; e_we <= 1'b0; e_dk <= 1'b1;
            e_dest <= 2'd0; e_data <= 8'h00; e_rv <= 1'b0; e_rpc <= 8'h00;
            chk("rst_req", dmem_req, 0);   chk("rst_we", dmem_we, 0);
            chk("rst_addr", dmem_addr, 0); chk("rst_wdata", dmem_wdata, 0);
            chk("rst_stall", stall_o, 0);  chk("rst_sp", sp_o, 8'hFF);
            chk("rst_redir", redir_valid, 0); chk("rst_rpc", redir_pc, 0);
            chk("rst_wbv", wb_valid, 0);   chk("rst_wbwe", wb_we, 0);
            chk("rst_wbd", wb_dest, 0);    chk("rst_wbdata", wb_data, 0);
        end else begin
            live = m_valid & (m_rd | m_wr);
            req  = busy | (live & ~flush_i);
            case (m_addr_sel)
                2'd0: a = m_alu;
                2'd1: a = m_src1;
                2'd2: a = m_imm;
                default: a = (m_sp_op && m_rd && !m_wr) ? mdl_sp + 8'd1 : mdl_sp;
            endcase
            case (m_wdata_sel)
                2'd0: wd = m_src1;
                2'd1: wd = m_src2;
                2'd2: wd = m_pc + 8'd1;
                default: wd = m_alu;
            endcase
            chk("req", dmem_req, req);
            chk("stall", stall_o, req & ~dmem_ack);
            if (req) begin
                chk("we", dmem_we, m_wr);
                chk("addr", dmem_addr, a);
                if (m_wr) chk("wdata", dmem_wdata, wd);
            end
            chk("sp", sp_o, mdl_sp);
            chk("wb_valid", wb_valid, e_wv);
            chk("wb_we", wb_we, e_we);
            if (e_wv) chk("wb_dest", wb_dest, e_dest);
            if (e_wv && e_dk) chk("wb_data", wb_data, e_data);
            chk("redir_valid", redir_valid, e_rv);
            if (e_rv) chk("redir_pc", redir_pc, e_rpc);
            if (stall_o) stall_cycles <= stall_cycles + 1;

            rdm  = mdl_mem[a];
            fire = req & dmem_ack;
            if (req && !dmem_ack) begin
                busy <= 1'b1; e_wv <= 1'b0; e_we <= 1'b0;
            end else begin
                killed = flush_i & ~busy;
                busy   <= 1'b0;
                e_wv   <= m_valid & ~killed & ~m_ret;
                e_we   <= m_valid & ~killed & ~m_ret & m_rf_we;
                e_dest <= m_dest;
                case (m_wb_sel)
                    2'd0: wbd = m_alu;
                    2'd1: wbd = rdm;
                    2'd2: wbd = m_imm;
                    default: wbd = m_src2;
                endcase
                e_data <= wbd;
                e_dk   <= !(m_wb_sel == 2'd1 && !req);
            end
            e_rv  <= fire & m_ret & m_rd & ~m_wr;
            e_rpc <= rdm;
            if (fire && m_wr) mdl_mem[a] <= wd;
            if (fire && m_sp_op) mdl_sp <= m_wr ? mdl_sp - 8'd1 : mdl_sp + 8'd1;
        end
    end

    // v rd wr sp ret | addr_sel wdata_sel wb_sel | rf_we dest | pc imm alu src1 src2
    function automatic bun_t mk(input logic v, rd, wr, sp, ret, input logic [1:0] as, ws, wbs,
                                input logic rfwe, input logic [1:0] dest,
                                input logic [7:0] pc, imm, alu, s1, s2);
        return {v, rd, wr, sp, ret, as, ws, wbs, rfwe, dest, pc, imm, alu, s1, s2};
    endfunction

    task automatic drv(input bun_t b);
        m_valid = b.v; m_rd = b.rd; m_wr = b.wr; m_sp_op = b.sp; m_ret = b.ret;
        m_addr_sel = b.as; m_wdata_sel = b.ws; m_wb_sel = b.wbs; m_rf_we = b.rfwe;
        m_dest = b.dest; m_pc = b.pc; m_imm = b.imm; m_alu = b.alu; m_src1 = b.s1; m_src2 = b.s2;
    endtask

    task automatic nop();
        drv('0);
        flush_i = 1'b0;
    endtask

    // Holds the bundle until the stage accepts it; returns just after the accepting edge.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (stall_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("accept_bound", stall_o, 0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input bun_t b, input int wt, input logic fl);
        drv(b); flush_i = fl; wait_n = wt;
        wait_accept();
    endtask

    int s0, w0;

    initial begin
        nop();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("lit_sp_after_reset", sp_o, 8'hFF);

        issue(mk(1,0,1,0,0, 2,1,0, 0,0, 8'h00,8'h40,8'h00,8'h00,8'h5A), 0, 0);

        s0 = stall_cycles;
        issue(mk(1,1,0,0,0, 2,0,1, 1,2, 8'h00,8'h40,8'h00,8'h00,8'h00), 0, 0);
        chk("lit_zw_stall", stall_cycles - s0, 0);
        chk("lit_zw_wbv", wb_valid, 1);
        chk("lit_zw_dest", wb_dest, 2);
        chk("lit_zw_data", wb_data, 8'h5A);

        s0 = stall_cycles; w0 = n_writes;
        issue(mk(1,0,1,0,0, 0,0,0, 0,0, 8'h00,8'h00,8'h10,8'h33,8'h00), 3, 0);
        chk("lit_st_stall", stall_cycles - s0, 3);
        chk("lit_st_writes", n_writes - w0, 1);
        chk("lit_st_mem", resp_mem[8'h10], 8'h33);

        issue(mk(1,0,1,1,0, 3,0,0, 0,0, 8'h00,8'h00,8'h00,8'h77,8'h00), 1, 0);
        chk("lit_push_sp", sp_o, 8'hFE);
        chk("lit_push_addr", last_addr, 8'hFF);
        issue(mk(1,1,0,1,0, 3,0,1, 1,1, 8'h00,8'h00,8'h00,8'h00,8'h00), 0, 0);
        chk("lit_pop_sp", sp_o, 8'hFF);
        chk("lit_pop_addr", last_addr, 8'hFF);
        chk("lit_pop_data", wb_data, 8'h77);
        chk("lit_pop_dest", wb_dest, 1);

        issue(mk(1,0,1,1,0, 3,2,0, 0,0, 8'h1F,8'h00,8'h00,8'h00,8'h00), 0, 0);
        issue(mk(1,1,0,1,1, 3,0,1, 1,0, 8'h00,8'h00,8'h00,8'h00,8'h00), 2, 0);
        chk("lit_ret_valid", redir_valid, 1);
        chk("lit_ret_pc", redir_pc, 8'h20);
        chk("lit_ret_wbv", wb_valid, 0);
        nop();

        issue(mk(1,0,0,0,0, 0,0,2, 1,3, 8'h00,8'hA5,8'h00,8'h00,8'h00), 0, 0);
        chk("lit_pass_imm", wb_data, 8'hA5);
        chk("lit_pass_we", wb_we, 1);
        issue(mk(1,0,0,0,0, 0,0,3, 1,0, 8'h00,8'h00,8'h00,8'h00,8'h3C), 0, 0);
        issue(mk(1,0,0,0,0, 0,0,0, 0,1, 8'h00,8'h00,8'h81,8'h00,8'h00), 0, 0);
        issue(mk(1,0,0,0,0, 0,0,0, 1,1, 8'h00,8'h00,8'h81,8'h00,8'h00), 0, 1);
        chk("lit_flush_nonmem", wb_valid, 0);
        issue(mk(1,1,0,0,0, 2,0,1, 1,2, 8'h00,8'h40,8'h00,8'h00,8'h00), 0, 1);
        chk("lit_flush_idle_ld", wb_valid, 0);

        drv(mk(1,1,0,0,0, 0,0,1, 1,3, 8'h00,8'h00,8'h10,8'h00,8'h00));
        flush_i = 1'b0; wait_n = 3;
        @(posedge clk); #1 flush_i = 1'b1;
        wait_accept();
        chk("lit_flush_wait_wbv", wb_valid, 1);
        chk("lit_flush_wait_data", wb_data, 8'h33);
        nop();

        for (int i = 0; i < 256; i++)
            issue(mk(1,0,1,1,0, 3,0,0, 0,0, 8'h00,8'h00,8'h00,8'(i),8'h00), 0, 0);
        chk("lit_wrap_sp", sp_o, 8'hFF);
        issue(mk(1,1,0,1,0, 3,0,1, 1,0, 8'h00,8'h00,8'h00,8'h00,8'h00), 0, 0);
        chk("lit_wrap_pop_addr", last_addr, 8'h00);
        chk("lit_wrap_pop_sp", sp_o, 8'h00);
        chk("lit_wrap_pop_data", wb_data, 8'hFF);

        w0 = n_writes;
        drv(mk(1,0,1,0,0, 2,0,0, 0,0, 8'h00,8'h90,8'h00,8'hEE,8'h00));
        flush_i = 1'b0; wait_n = 5;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_req", dmem_req, 0);
        chk("lit_rst_stall", stall_o, 0);
        chk("lit_rst_sp", sp_o, 8'hFF);
        nop();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_sp_after", sp_o, 8'hFF);
        chk("lit_rst_no_write", n_writes - w0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Memory-stage engine; consumes the registered EX/MEM bundle, i.e. it is the reader side of the EX/MEM latch.
- Drives the data-memory request/ack handshake and owns the stack pointer.
- Sequences RET pops into a PC redirect and registers the MEM/WB bundle for writeback.
- Back-pressures EX/MEM and upstream stages via stall_o while a memory access is outstanding.

Parameters:
- DATA_W, 8, datapath width.
- SP_INIT, 8'hFF, stack pointer value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_valid  in  1  EX/MEM bundle holds a live instruction.
- m_rd  in  1  data memory read enable.
- m_wr  in  1  data memory write enable.
- m_sp_op  in  1  access is a stack push (with m_wr) or pop (with m_rd).
- m_ret  in  1  RET instruction; the popped byte becomes the new PC.
- m_addr_sel  in  2  address source: 0 alu, 1 src1, 2 imm, 3 stack.
- m_wdata_sel  in  2  write-data source: 0 src1, 1 src2, 2 pc+1, 3 alu.
- m_wb_sel  in  2  writeback source: 0 alu, 1 mem rdata, 2 imm, 3 src2.
- m_rf_we  in  1  register-file write enable.
- m_dest  in  2  destination register.
- m_pc, m_imm, m_alu, m_src1, m_src2  in  8 each  bundle data.
- flush_i  in  1  kill the current bundle if its access has not started.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write, when set.
- dmem_addr  out  8  memory address.
- dmem_wdata  out  8  write data.
- dmem_ack  in  1  request accepted; read data is valid in this same cycle.
- dmem_rdata  in  8  read data.
- stall_o  out  1  hold EX/MEM and all upstream stages.
- sp_o  out  8  current stack pointer.
- redir_valid  out  1  one-cycle pulse: redirect fetch.
- redir_pc  out  8  RET target.
- wb_valid, wb_we  out  1 each  registered MEM/WB bundle flags.
- wb_dest  out  2  registered destination register.
- wb_data  out  8  registered writeback data.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, sp=SP_INIT.
  - All outputs 0, except sp_o=SP_INIT.
  - An in-flight access is abandoned; no SP update, no writeback.
- Live op: mem_op = m_valid & (m_rd | m_wr). m_rd and m_wr never both set; if they are, treat the op as a write.
- Addressing:
  - m_addr_sel=3 with a push: address = sp.
  - m_addr_sel=3 with a pop: address = sp+1, mod 256.
  - dmem_we = m_wr.
  - pc+1 is computed mod 256.
- IDLE state:
  - If mem_op & ~flush_i, assert dmem_req combinationally.
  - If dmem_ack is set in the same cycle: complete (zero-wait).
  - Otherwise go to WAIT.
  - stall_o = mem_op & ~flush_i & ~dmem_ack.
- WAIT state:
  - Hold dmem_req and its attributes until dmem_ack is set; stall_o = ~dmem_ack.
  - The bundle inputs are guaranteed stable, because they are stalled.
  - flush_i is ignored in WAIT: a started access always completes.
  - On ack, complete and return to IDLE.
- Completion (posedge after the ack cycle):
  - Push: sp <= sp-1. Pop: sp <= sp+1. Both wrap mod 256 (0x00-1=0xFF, 0xFF+1=0x00).
  - m_ret & m_rd: redir_valid=1, redir_pc=dmem_rdata for one cycle, with no writeback.
- Writeback:
  - The wb_* registers load on every non-stalled cycle.
  - wb_valid = m_valid & ~flush_i & ~m_ret.
  - wb_we = wb_valid & m_rf_we.
  - wb_data is selected per m_wb_sel; rdata is sampled in the ack cycle.
  - Stalled cycles load a bubble: wb_valid=0, wb_we=0.
- Non-memory ops pass through with 1-cycle latency and no stall.
- Back-to-back accesses:
  - The next bundle may issue in the cycle after completion.
  - Throughput is one access per cycle with a zero-wait memory.
- flush_i with a non-memory op: produces a bubble.

Decomposition:
- Package mem_stage_pkg:
  - Select encodings: ADDR_SEL_*, WDATA_SEL_*, WB_SEL_*.
  - State enum {IDLE, WAIT}.
  - SP_INIT default.
- One sub-module, mem_sp_reg: the SP register with push/pop enables and wrap.

Test Plan:
- Zero-wait load: m_rd, addr_sel=2, imm=0x40, ack same cycle, rdata=0x5A, wb_sel=1, dest=2 -> stall_o never high; next cycle wb_valid=1, wb_dest=2, wb_data=0x5A.
- Stalled store: m_wr, addr_sel=0, alu=0x10, src1=0x33, ack after 3 cycles -> stall_o high for 3 cycles; req/addr/wdata stable; bubbles on wb; one write of 0x33 to 0x10.
- Push then pop: push with wdata_sel=0, src1=0x77 -> addr 0xFF, sp=0xFE. Pop with dest=1 -> addr 0xFF, sp=0xFF, wb_data=0x77.
- RET: push pc=0x1F with wdata_sel=2, then RET pop -> redir_valid pulse with redir_pc=0x20, wb_valid=0.
- SP wrap: 256 consecutive pushes -> sp returns to 0xFF; one more pop from 0xFF reads addr 0x00 and sp becomes 0x00.
- Reset mid-WAIT: drop rst_n while a 5-cycle store waits -> dmem_req=0, stall_o=0 immediately; sp=0xFF; no SP change after release.
- Flush in WAIT: flush_i asserted during a waiting load -> the access still completes and writes back.
